// File: rtl/yc_noc_wh_outport_ctrl.sv
// Wormhole output-port controller: round-robin head arbitration, per-packet lock, credit metering.
// Optional downstream credit-overflow detection under YC_NOC_CREDIT_CHECK_EN.
module yc_noc_wh_outport_ctrl #(
    parameter int N       = 5,
    parameter int FW      = 34,
    parameter int CREDITS = 4,
    localparam int PW     = (N <= 2) ? 1 : $clog2(N),
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_tail,
    input  logic [N*FW-1:0] in_flit,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [FW-1:0]   out_flit,
    output logic            out_tail,
    input  logic            credit_ret,
    output logic            busy,
    output logic [PW-1:0]   owner,
    output logic            credit_err
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   owner_r;
    logic [CW-1:0]   credits_r;
    logic            out_valid_r;
    logic [FW-1:0]   out_flit_r;
    logic            out_tail_r;
    logic            busy_r;

    logic            can_send_s;
    logic [PW:0]     pick_s;
    logic [N-1:0]    ready_s;
    logic [PW-1:0]   sel_s;
    logic            xfer_s;
    logic            tail_s;
    logic [FW-1:0]   flit_s;

    // Returns {found, index} of the first requester at or after start, wrapping modulo N.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] start);
        logic [PW:0] res;
        int          idx;
        res = {(PW+1){1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[PW'(idx)]) begin
                res = {1'b1, PW'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] x);
        return (x == PW'(N - 1)) ? {PW{1'b0}} : x + PW'(1);
    endfunction

    assign can_send_s = (credits_r != {CW{1'b0}});
    assign pick_s     = rr_pick(in_valid, ptr_r);

    // Grant generation: scan from ptr when idle, only the owner while locked.
    always_comb begin
        ready_s = {N{1'b0}};
        sel_s   = owner_r;
        case (state_r)
            IDLE: begin
                if (can_send_s && pick_s[PW]) begin
                    sel_s          = pick_s[PW-1:0];
                    ready_s[sel_s] = 1'b1;
                end else begin
                    sel_s = owner_r;
                end
            end
            LOCKED: begin
                if (can_send_s) begin
                    ready_s[owner_r] = 1'b1;
                end else begin
                    ready_s = {N{1'b0}};
                end
            end
            default: begin
                ready_s = {N{1'b0}};
                sel_s   = owner_r;
            end
        endcase
    end

    assign xfer_s = |(in_valid & ready_s);
    assign tail_s = in_tail[sel_s];
    assign flit_s = in_flit[int'(sel_s)*FW +: FW];

    // Lock FSM, round-robin pointer, credit counter and output flit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {PW{1'b0}};
            owner_r     <= {PW{1'b0}};
            credits_r   <= CW'(CREDITS);
            out_valid_r <= 1'b0;
            out_flit_r  <= {FW{1'b0}};
            out_tail_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= xfer_s;
            if (xfer_s) begin
                out_flit_r <= flit_s;
                out_tail_r <= tail_s;
            end
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        owner_r <= sel_s;
                        if (tail_s) begin
                            ptr_r <= inc_mod(sel_s);
                        end else begin
                            state_r <= LOCKED;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer_s && tail_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ptr_r   <= inc_mod(owner_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            case ({xfer_s, credit_ret})
                2'b10:   credits_r <= credits_r - CW'(1);
                2'b01: begin
                    if (credits_r != CW'(CREDITS)) begin
                        credits_r <= credits_r + CW'(1);
                    end
                end
                default: credits_r <= credits_r;
            endcase
        end
    end

`ifdef YC_NOC_CREDIT_CHECK_EN
    logic credit_err_r;

    // Sticky flag: a returned credit while the counter is already full means downstream miscounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_err_r <= 1'b0;
        end else if (credit_ret && !xfer_s && (credits_r == CW'(CREDITS))) begin
            credit_err_r <= 1'b1;
        end
    end

    assign credit_err = credit_err_r;
`else
    assign credit_err = 1'b0;
`endif

    assign in_ready  = ready_s;
    assign out_valid = out_valid_r;
    assign out_flit  = out_flit_r;
    assign out_tail  = out_tail_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_yc_noc_wh_outport_ctrl.sv
// Scoreboard bench for yc_noc_wh_outport_ctrl: behavioural arbiter/credit model plus directed and random traffic.
module tb_yc_noc_wh_outport_ctrl;

    localparam int N       = 5;
    localparam int FW      = 34;
    localparam int CREDITS = 4;
    localparam int PW      = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_tail;
    logic [N*FW-1:0] in_flit;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [FW-1:0]   out_flit;
    logic            out_tail;
    logic            credit_ret;
    logic            busy;
    logic [PW-1:0]   owner;
    logic            credit_err;

    yc_noc_wh_outport_ctrl #(.N(N), .FW(FW), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_tail(in_tail), .in_flit(in_flit), .in_ready(in_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_tail(out_tail),
        .credit_ret(credit_ret), .busy(busy), .owner(owner), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Traffic sources: remaining flits of the current packet and a per-input flit counter.
    int         rem [N];
    int         cnt [N];
    logic [N-1:0] bub;

    // Reference model state.
    bit m_locked;
    int m_ptr, m_owner, m_cred;
    bit m_err;

    logic [FW:0] sb_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] flit_of(input int i);
        return {4'(i), 30'(cnt[i])};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            in_valid[i]           = (rem[i] != 0) && !bub[i];
            in_tail[i]            = (rem[i] == 1);
            in_flit[i*FW +: FW]   = flit_of(i);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        m_cred   = CREDITS;
        m_err    = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        bub = '0;
        sb_q.delete();
    endtask

    // One clock cycle: predict grant, push expected flit, advance model, check registered outputs.
    task automatic cycle(input logic ret);
        logic [N-1:0] m_rdy;
        bit           xfer, ttail;
        int           sel, idx;
        logic [FW:0]  got;
        logic [FW:0]  exp;
        credit_ret = ret;
        drive();
        #1;
        m_rdy = '0;
        sel   = m_owner;
        if (m_cred != 0) begin
            if (m_locked) begin
                m_rdy[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (in_valid[idx] && m_rdy == '0) begin
                        m_rdy[idx] = 1'b1;
                        sel        = idx;
                    end
                end
            end
        end
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        xfer  = (rem[sel] != 0) && !bub[sel] && m_rdy[sel];
        ttail = (rem[sel] == 1);
        if (xfer) sb_q.push_back({ttail, flit_of(sel)});
        @(posedge clk);
        if (ret && !xfer && m_cred == CREDITS) begin
`ifdef YC_NOC_CREDIT_CHECK_EN
            m_err = 1'b1;
`endif
        end
        if (xfer && !ret) m_cred--;
        else if (ret && !xfer && m_cred < CREDITS) m_cred++;
        if (xfer) begin
            if (!m_locked) begin
                m_owner = sel;
                if (ttail) m_ptr = (sel + 1) % N;
                else m_locked = 1'b1;
            end else if (ttail) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
            rem[sel]--;
            cnt[sel]++;
        end
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(xfer));
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 64'(1), 64'(0));
            end else begin
                exp = sb_q.pop_front();
                got = {out_tail, out_flit};
                check("out_flit", 64'(got[FW-1:0]), 64'(exp[FW-1:0]));
                check("out_tail", 64'(got[FW]), 64'(exp[FW]));
            end
        end else if (xfer && sb_q.size() != 0) begin
            void'(sb_q.pop_back());
        end
        check("busy", 64'(busy), 64'(m_locked));
        check("owner", 64'(owner), 64'(m_owner));
        check("credit_err", 64'(credit_err), 64'(m_err));
    endtask

    task automatic cycle_auto();
        cycle(m_cred < CREDITS);
    endtask

    // Finish outstanding packets and refill credits without over-returning.
    task automatic drain();
        bit pending;
        for (int g = 0; g < 100; g++) begin
            pending = (m_cred < CREDITS);
            for (int i = 0; i < N; i++) if (rem[i] != 0) pending = 1'b1;
            if (pending) cycle_auto();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        credit_ret = 1'b0;
        drive();
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_flit", 64'(out_flit), 64'(0));
        check("rst_out_tail", 64'(out_tail), 64'(0));
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_credit_err", 64'(credit_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        credit_ret = 1'b0;
        in_valid   = '0;
        in_tail    = '0;
        in_flit    = '0;
        for (int i = 0; i < N; i++) cnt[i] = i * 100;
        model_reset();
        @(negedge clk);
        do_reset();

        // Two single-flit packets on inputs 1 and 3, then 0 and 4 to expose ptr=4.
        rem[1] = 1; rem[3] = 1;
        cycle_auto(); cycle_auto();
        check("t1_ptr_owner", 64'(owner), 64'(3));
        rem[0] = 1; rem[4] = 1;
        cycle_auto();
        check("t1_ptr_wrap", 64'(owner), 64'(4));
        drain();

        // Three-flit packet on input 2 while input 0 waits.
        rem[2] = 3; rem[0] = 2;
        for (int c = 0; c < 6; c++) cycle_auto();
        drain();

        // Credit exhaustion and single-credit refill.
        rem[0] = 6;
        for (int c = 0; c < 7; c++) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        drain();

        // Transfer and credit return in the same cycle at credits=2.
        rem[1] = 2;
        cycle(1'b0); cycle(1'b0);
        rem[2] = 1;
        cycle(1'b1);
        rem[3] = 3;
        for (int c = 0; c < 4; c++) cycle(1'b0);
        drain();

        // Reset while locked to input 4.
        rem[4] = 3;
        cycle(1'b0);
        check("t5_locked", 64'(busy), 64'(1));
        do_reset();
        rem[4] = 1; rem[1] = 1;
        for (int c = 0; c < 3; c++) cycle_auto();
        drain();

        // Credit return with a full counter.
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);

        // Random traffic with owner bubbles and random credit returns.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(3, 0) == 0) rem[i] = $urandom_range(4, 1);
                bub[i] = ($urandom_range(4, 0) == 0);
            end
            cycle(1'($urandom_range(1, 0)));
        end
        bub = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
